// File: rtl/dbus_sequencer.sv
// Converts the single-cycle MEM-stage data-bus request into a req/addr_ok/data_ok
// memory transaction, handling lane alignment, address checks and pipeline stall.
module dbus_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbus_en,
  input  logic [3:0]  dbus_we,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_data,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        adel,
  output logic        ades,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    off_q, off_d;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   raw_q, raw_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          mis;
  logic          req_live;
  logic          capture;
  logic [1:0]    size_n;
  logic [31:0]   wdata_rep;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  // Size 11 is normalised to word so the memory port only ever sees legal sizes.
  always_comb begin
    size_n    = (req_size == 2'b11) ? 2'b10 : req_size;
    mis       = ((req_size == 2'b01) & dbus_addr[0]) | (req_size[1] & (dbus_addr[1:0] != 2'b00));
    req_live  = (state_q == IDLE) & dbus_en & !flush;
    capture   = req_live & !mis;
    wdata_rep = dbus_data;
    case (size_n)
      2'b00:   wdata_rep = {4{dbus_data[7:0]}};
      2'b01:   wdata_rep = {2{dbus_data[15:0]}};
      default: wdata_rep = dbus_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    write_d = write_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    raw_d   = raw_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = REQ;
          off_d   = dbus_addr[1:0];
          write_d = |dbus_we;
          size_d  = size_n;
          sext_d  = req_sext;
          addr_d  = dbus_addr;
          wstrb_d = dbus_we << dbus_addr[1:0];
          wdata_d = wdata_rep;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (mem_addr_ok) begin
          if (mem_data_ok) begin
            raw_d   = mem_rdata;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (mem_data_ok) begin
          raw_d   = mem_rdata;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      raw_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      write_q <= write_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      raw_q   <= raw_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load data is extracted from the lane selected by the latched byte offset.
  always_comb begin
    rd_byte = raw_q[7:0];
    case (off_q)
      2'd1:    rd_byte = raw_q[15:8];
      2'd2:    rd_byte = raw_q[23:16];
      2'd3:    rd_byte = raw_q[31:24];
      default: rd_byte = raw_q[7:0];
    endcase
    rd_half = off_q[1] ? raw_q[31:16] : raw_q[15:0];
    rdata   = raw_q;
    case (size_q)
      2'b00:   rdata = {{24{sext_q & rd_byte[7]}}, rd_byte};
      2'b01:   rdata = {{16{sext_q & rd_half[15]}}, rd_half};
      default: rdata = raw_q;
    endcase
  end

  always_comb begin
    stall       = capture | (state_q == REQ) | (state_q == WAIT);
    adel        = req_live & mis & (dbus_we == 4'b0000);
    ades        = req_live & mis & (dbus_we != 4'b0000);
    mem_req     = (state_q == REQ);
    mem_wr      = (state_q == REQ) & write_q;
    mem_size    = size_q;
    mem_addr    = addr_q;
    mem_wstrb   = wstrb_q;
    mem_wdata   = wdata_q;
    rdata_valid = (state_q == DONE) & !write_q & !err_q;
    bus_err     = (state_q == DONE) & err_q;
  end

endmodule

// File: tb/tb_dbus_sequencer.sv
// Self-checking bench for dbus_sequencer: table-driven transactions through a
// scoreboard plus hand-written flush, timeout and async-reset sequences.
module tb_dbus_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbus_en, to_en;
  logic [3:0]  dbus_we;
  logic [31:0] dbus_addr, dbus_data;
  logic [1:0]  req_size;
  logic        req_sext, flush;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  logic        stall, rdata_valid, adel, ades, bus_err, mem_req, mem_wr;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;

  logic        to_stall, to_rdata_valid, to_adel, to_ades, to_bus_err, to_mem_req, to_mem_wr;
  logic [31:0] to_rdata, to_mem_addr, to_mem_wdata;
  logic [1:0]  to_mem_size;
  logic [3:0]  to_mem_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] mrd;
    logic        same;
    logic [31:0] exp_rdata;
    logic        exp_valid;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [1:0]  exp_size;
    logic        exp_adel;
    logic        exp_ades;
  } vec_t;

  vec_t vecs[13];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  dbus_sequencer dut (
    .clk(clk), .rst(rst), .dbus_en(dbus_en), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_data(dbus_data), .req_size(req_size), .req_sext(req_sext), .flush(flush),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .adel(adel), .ades(ades),
    .bus_err(bus_err), .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  dbus_sequencer #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .dbus_en(to_en), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_data(dbus_data), .req_size(req_size), .req_sext(req_sext), .flush(flush),
    .stall(to_stall), .rdata(to_rdata), .rdata_valid(to_rdata_valid), .adel(to_adel),
    .ades(to_ades), .bus_err(to_bus_err), .mem_req(to_mem_req), .mem_wr(to_mem_wr),
    .mem_size(to_mem_size), .mem_addr(to_mem_addr), .mem_wstrb(to_mem_wstrb),
    .mem_wdata(to_mem_wdata), .mem_addr_ok(1'b0), .mem_data_ok(1'b0), .mem_rdata(32'h0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one table entry, acts as the memory, and pops the scoreboard when the result appears.
  task automatic applyStimulus(input vec_t v);
    vec_t e;
    @(posedge clk); #1;
    dbus_en = 1'b1; dbus_we = v.we; dbus_addr = v.addr; dbus_data = v.data;
    req_size = v.size; req_sext = v.sext; flush = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    exp_q.push_back(v);
    @(negedge clk);
    if (v.exp_adel || v.exp_ades) begin
      checkOutput("sb_depth_err", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("adel", adel, e.exp_adel);
        checkOutput("ades", ades, e.exp_ades);
      end
      checkOutput("mis_stall", stall, 0);
      checkOutput("mis_mem_req", mem_req, 0);
      @(posedge clk); #1;
      dbus_en = 1'b0;
      @(negedge clk);
      checkOutput("mis_after_req", mem_req, 0);
      checkOutput("mis_after_stall", stall, 0);
      checkOutput("mis_after_adel", adel, 0);
    end else begin
      checkOutput("cap_stall", stall, 1);
      checkOutput("cap_mem_req", mem_req, 0);
      @(posedge clk); #1;
      mem_addr_ok = 1'b1; mem_data_ok = v.same; mem_rdata = v.mrd;
      @(negedge clk);
      checkOutput("req_mem_req", mem_req, 1);
      checkOutput("req_stall", stall, 1);
      checkOutput("req_mem_wr", mem_wr, (v.we != 4'b0000));
      checkOutput("req_mem_size", mem_size, v.exp_size);
      checkOutput("req_mem_addr", mem_addr, v.addr);
      checkOutput("req_mem_wstrb", mem_wstrb, v.exp_wstrb);
      checkOutput("req_mem_wdata", mem_wdata, v.exp_wdata);
      if (!v.same) begin
        @(posedge clk); #1;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        @(negedge clk);
        checkOutput("wait1_mem_req", mem_req, 0);
        checkOutput("wait1_stall", stall, 1);
        @(posedge clk); #1;
        mem_data_ok = 1'b1;
        @(negedge clk);
        checkOutput("wait2_stall", stall, 1);
        checkOutput("wait2_mem_req", mem_req, 0);
      end
      @(posedge clk); #1;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
      @(negedge clk);
      checkOutput("sb_depth_done", exp_q.size(), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("done_rdata_valid", rdata_valid, e.exp_valid);
        if (e.exp_valid) checkOutput("done_rdata", rdata, e.exp_rdata);
      end
      checkOutput("done_bus_err", bus_err, 0);
      checkOutput("done_stall", stall, 0);
      checkOutput("done_mem_req", mem_req, 0);
    end
  endtask

  initial begin
    int req_cycles;
    vecs[0]  = '{4'b0000, 32'h100, 32'h12345678, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b1, 4'b0000, 32'h12345678, 2'b10, 1'b0, 1'b0};
    vecs[1]  = '{4'b0000, 32'h103, 32'h000000AA, 2'b00, 1'b1, 32'h80FF1234, 1'b1, 32'hFFFFFF80, 1'b1, 4'b0000, 32'hAAAAAAAA, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{4'b0000, 32'h103, 32'h000000AA, 2'b00, 1'b0, 32'h80FF1234, 1'b1, 32'h00000080, 1'b1, 4'b0000, 32'hAAAAAAAA, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{4'b0011, 32'h202, 32'h0000ABCD, 2'b01, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 4'b1100, 32'hABCDABCD, 2'b01, 1'b0, 1'b0};
    vecs[4]  = '{4'b0000, 32'h102, 32'h00000000, 2'b01, 1'b1, 32'h80017FFF, 1'b0, 32'hFFFF8001, 1'b1, 4'b0000, 32'h00000000, 2'b01, 1'b0, 1'b0};
    vecs[5]  = '{4'b0000, 32'h100, 32'h00000000, 2'b01, 1'b0, 32'h8001F00D, 1'b1, 32'h0000F00D, 1'b1, 4'b0000, 32'h00000000, 2'b01, 1'b0, 1'b0};
    vecs[6]  = '{4'b0001, 32'h301, 32'h0000005A, 2'b00, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 4'b0010, 32'h5A5A5A5A, 2'b00, 1'b0, 1'b0};
    vecs[7]  = '{4'b1111, 32'h400, 32'hCAFEF00D, 2'b10, 1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 4'b1111, 32'hCAFEF00D, 2'b10, 1'b0, 1'b0};
    vecs[8]  = '{4'b0000, 32'h500, 32'h00000000, 2'b11, 1'b1, 32'h11223344, 1'b1, 32'h11223344, 1'b1, 4'b0000, 32'h00000000, 2'b10, 1'b0, 1'b0};
    vecs[9]  = '{4'b0000, 32'h101, 32'h00000000, 2'b10, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 4'b0000, 32'h00000000, 2'b10, 1'b1, 1'b0};
    vecs[10] = '{4'b1111, 32'h106, 32'h00000000, 2'b10, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 4'b0000, 32'h00000000, 2'b10, 1'b0, 1'b1};
    vecs[11] = '{4'b0000, 32'h103, 32'h00000000, 2'b01, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 4'b0000, 32'h00000000, 2'b01, 1'b1, 1'b0};
    vecs[12] = '{4'b0000, 32'h102, 32'h00000000, 2'b00, 1'b1, 32'h00AB0000, 1'b1, 32'hFFFFFFAB, 1'b1, 4'b0000, 32'h00000000, 2'b00, 1'b0, 1'b0};

    rst = 1'b1; dbus_en = 1'b0; to_en = 1'b0; dbus_we = '0; dbus_addr = '0; dbus_data = '0;
    req_size = '0; req_sext = 1'b0; flush = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    #12;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_rdata_valid", rdata_valid, 0);
    checkOutput("rst_adel", adel, 0);
    checkOutput("rst_ades", ades, 0);
    checkOutput("rst_bus_err", bus_err, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_wr", mem_wr, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_mem_wstrb", mem_wstrb, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);
    @(posedge clk); #1;
    dbus_en = 1'b0;

    // Flush blocks capture, misalignment errors and stall.
    @(posedge clk); #1;
    dbus_en = 1'b1; dbus_we = 4'b0000; dbus_addr = 32'h100; req_size = 2'b10; flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_stall", stall, 0);
    @(posedge clk); #1;
    dbus_addr = 32'h101;
    @(negedge clk);
    checkOutput("flush_no_req", mem_req, 0);
    checkOutput("flush_no_adel", adel, 0);
    checkOutput("flush_stall2", stall, 0);
    @(posedge clk); #1;
    dbus_en = 1'b0; flush = 1'b0; dbus_addr = 32'h100;

    // Address-phase timeout on the short-timeout instance.
    @(posedge clk); #1;
    to_en = 1'b1;
    @(negedge clk);
    checkOutput("to_cap_stall", to_stall, 1);
    req_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (to_mem_req) begin
        req_cycles++;
        checkOutput("to_req_bus_err", to_bus_err, 0);
      end else begin
        break;
      end
    end
    checkOutput("to_req_cycles", req_cycles, 4);
    checkOutput("to_bus_err", to_bus_err, 1);
    checkOutput("to_rdata_valid", to_rdata_valid, 0);
    checkOutput("to_done_stall", to_stall, 0);
    @(posedge clk); #1;
    to_en = 1'b0;
    @(negedge clk);
    checkOutput("to_idle_bus_err", to_bus_err, 0);
    checkOutput("to_idle_req", to_mem_req, 0);

    // Asynchronous reset while waiting for the data phase.
    @(posedge clk); #1;
    dbus_en = 1'b1; dbus_we = 4'b0000; dbus_addr = 32'h600; req_size = 2'b10; req_sext = 1'b0;
    @(posedge clk); #1;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
    @(negedge clk);
    checkOutput("rw_req", mem_req, 1);
    @(posedge clk); #1;
    mem_addr_ok = 1'b0;
    @(negedge clk);
    checkOutput("rw_wait_stall", stall, 1);
    #2;
    rst = 1'b1; dbus_en = 1'b0;
    #1;
    checkOutput("rw_rst_stall", stall, 0);
    checkOutput("rw_rst_mem_req", mem_req, 0);
    checkOutput("rw_rst_rdata_valid", rdata_valid, 0);
    checkOutput("rw_rst_bus_err", bus_err, 0);
    checkOutput("rw_rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(vecs[0]);
    @(posedge clk); #1;
    dbus_en = 1'b0;
    @(negedge clk);
    checkOutput("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_sequencer.md
Name: dbus_sequencer

Overview:
- Turns the single-cycle data-bus request from the MEM-stage memory control into a multi-cycle req/addr_ok/data_ok transaction on the memory port.
- Aligns write data and byte strobes, checks address alignment, and aligns and extends read data.
- Stalls the pipeline until the transaction completes.
- Sits between the MEM stage and the data SRAM/cache bridge.

Parameters:
TIMEOUT_CYCLES, 255, REQ-state cycles without mem_addr_ok before bus_err; min 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- dbus_en  in  1  access request from MEM stage.
- dbus_we  in  4  unshifted write enables: 0001 SB, 0011 SH, 1111 SW, 0000 load.
- dbus_addr  in  32  byte address.
- dbus_data  in  32  store data, low-aligned.
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- req_sext  in  1  sign-extend load result.
- flush  in  1  cancel the request before issue.
- stall  out  1  hold the pipeline.
- rdata  out  32  aligned, extended load data.
- rdata_valid  out  1  rdata usable this cycle.
- adel  out  1  load address error.
- ades  out  1  store address error.
- bus_err  out  1  address-phase timeout.
- mem_req  out  1  memory request.
- mem_wr  out  1  write.
- mem_size  out  2  transfer size.
- mem_addr  out  32  address.
- mem_wstrb  out  4  byte strobes.
- mem_wdata  out  32  lane-replicated write data.
- mem_addr_ok  in  1  address accepted.
- mem_data_ok  in  1  data phase done.
- mem_rdata  in  32  read data.

Behaviour:
Reset and clocking:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset forces state IDLE and clears all registered outputs and latches.
- After reset: stall, rdata_valid, adel, ades, bus_err, mem_req and mem_wr are 0; rdata, mem_addr, mem_wdata and mem_wstrb are 0.
- Reset mid-transaction abandons it silently.

Alignment (combinational on inputs):
- mis = (size==01 & addr[0]) | (size==1x & addr[1:0]!=0).
- In IDLE with dbus_en & !flush & mis: adel = (dbus_we==0), ades = (dbus_we!=0).
- That case issues no transaction, stall=0, and stays in IDLE.

Capture (on the edge, when IDLE & dbus_en & !flush & !mis):
- Latch off = addr[1:0], write = |dbus_we, size, sext, and addr with low bits kept.
- Latch wstrb = dbus_we << off.
- Latch wdata: byte data[7:0] replicated x4; half data[15:0] x2; word as-is.
- Go to REQ.
- stall is asserted combinationally in the capture cycle.

States:
- IDLE:
  - Handles capture as above.
  - flush=1 blocks capture, errors and stall.
- REQ:
  - mem_req=1; mem_* driven from latches.
  - mem_addr_ok=1 & mem_data_ok=1 same cycle: latch mem_rdata, go to DONE.
  - mem_addr_ok only: go to WAIT.
  - The counter counts REQ cycles. At count==TIMEOUT_CYCLES-1 without mem_addr_ok: go to DONE with error flag set.
- WAIT:
  - mem_req=0.
  - mem_data_ok: latch mem_rdata, go to DONE. No timeout.
- DONE:
  - One cycle, then IDLE. No capture in DONE, because the upstream request is still present.
  - rdata_valid=1 for a completed load; 0 for a store or an error.
  - bus_err=1 if the error flag is set.
  - rdata: select the byte/half at the latched off; sext or zero-extend; word passes through.

Stall rule:
- stall = capture_cond | REQ | WAIT. It is 0 in DONE, so the instruction advances at the end of DONE.

Other rules:
- flush in REQ/WAIT/DONE is ignored; an issued access always completes, and the pipeline discards it.
- mem_data_ok outside REQ/WAIT is ignored.
- The counter clears on entering REQ.
- mem_wr, mem_size, mem_wstrb and mem_wdata are stable for the whole of REQ.
- Back-to-back: a request can be captured in the IDLE cycle immediately after DONE. Minimum load-to-load issue interval is 3 cycles.

Test Plan:
1. Word load:
   - Stimulus: LW addr 0x100, addr_ok in REQ cycle 1, data_ok 2 cycles later with rdata 0xDEADBEEF.
   - Response: mem_req high exactly 1 cycle; stall high 4 cycles; DONE gives rdata=0xDEADBEEF, rdata_valid=1.
2. Byte load, signed vs unsigned:
   - Stimulus: LB addr 0x103 sext=1, mem_rdata 0x80FF1234, addr_ok and data_ok same cycle.
   - Response: rdata=0xFFFFFF80. Same with sext=0: rdata=0x00000080. Neither case enters WAIT.
3. Half store:
   - Stimulus: SH addr 0x202, data 0x0000ABCD.
   - Response: mem_wstrb=1100, mem_wdata=0xABCDABCD, mem_wr=1, mem_size=01; DONE has rdata_valid=0.
4. Misaligned access:
   - Stimulus: LW addr 0x101; SW addr 0x106.
   - Response: adel=1 for the first and ades=1 for the second, each 1 cycle; mem_req never asserts; stall=0.
5. Flush and addr_ok timeout:
   - Stimulus: flush=1 with a valid LW.
   - Response: no capture, stall=0.
   - Stimulus: a TIMEOUT_CYCLES=4 instance with mem_addr_ok tied 0.
   - Response: DONE after 4 REQ cycles, bus_err=1, rdata_valid=0, then IDLE.
6. Async reset in WAIT:
   - Stimulus: assert rst between clock edges while in WAIT.
   - Response: stall, mem_req and all flags go 0 immediately.
   - Stimulus: a following LW after reset release.
   - Response: completes normally.
